reg_slice_skid: RTL and testbench

- Parametrised successor to the plain 8-bit enable register.
- Pipeline register stage with a valid/ready handshake on both sides.
- An optional skid entry gives full throughput with registered ready (no combinational ready path).
- Inserted between the SRAM/FIFO datapath and its consumers to break timing paths without losing data under backpressure.

---
 rtl/reg_slice_skid.sv | 130 +++++++++++++
 tb/tb_reg_slice_skid.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_slice_skid.sv
`default_nettype none
// ============================================================================
// Module      : reg_slice_skid
// Description : Valid/ready pipeline register slice. With SKID=1 a second
//               (skid) entry lets the slice sustain one transfer per cycle
//               while s_ready stays a pure register output. With SKID=0 the
//               slice holds one entry and moves at most one item per two
//               cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_slice_skid #(
    parameter int               WIDTH     = 8,
    parameter int               SKID      = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             s_ready_q, s_ready_d;
    logic             m_valid_q, m_valid_d;
    logic [1:0]       occ_q, occ_d;
    logic             w_in;
    logic             w_out;

    assign w_in  = s_valid & s_ready_q;
    assign w_out = m_valid_q & m_ready;

    // Next-state, data movement and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Entries are dropped; data registers deliberately keep contents.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (w_in) begin
                        state_d = BUSY;
                        main_d  = s_data;
                    end
                end
                BUSY: begin
                    if (SKID != 0) begin
                        if (w_in && !w_out) begin
                            state_d = FULL;
                            skid_d  = s_data;
                        end else if (w_in && w_out) begin
                            main_d  = s_data;
                        end else if (w_out) begin
                            state_d = EMPTY;
                        end
                    end else begin
                        // s_ready is low while BUSY, so only a drain can occur.
                        if (w_out) begin
                            state_d = EMPTY;
                        end
                    end
                end
                FULL: begin
                    if (w_out) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end

        // Ready is computed from the next state so it can be registered.
        if (SKID != 0) begin
            s_ready_d = (state_d != FULL);
        end else begin
            s_ready_d = (state_d == EMPTY);
        end
        m_valid_d = (state_d != EMPTY);
        case (state_d)
            BUSY:    occ_d = 2'd1;
            FULL:    occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
    end

    // State, data and output registers; async reset forces s_ready low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            main_q    <= RESET_VAL;
            skid_q    <= RESET_VAL;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            occ_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            occ_q     <= occ_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_data    = main_q;
    assign occupancy = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_slice_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_slice_skid
// Description : Self-checking bench for reg_slice_skid. Instance A is a
//               32-bit skid slice, instance B an 8-bit single-entry slice.
//               A queue model per instance predicts outputs every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_slice_skid;

    localparam logic [31:0] C_RV_A = 32'h0000_00C3;
    localparam logic [7:0]  C_RV_B = 8'h5C;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_flush, a_sv, a_sr, a_mv, a_mr;
    logic [31:0] a_sd, a_md;
    logic [1:0]  a_occ;

    logic        b_flush, b_sv, b_sr, b_mv, b_mr;
    logic [7:0]  b_sd, b_md;
    logic [1:0]  b_occ;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_slice_skid #(.WIDTH(32), .SKID(1), .RESET_VAL(C_RV_A)) u_dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .s_valid(a_sv), .s_ready(a_sr), .s_data(a_sd),
        .m_valid(a_mv), .m_ready(a_mr), .m_data(a_md),
        .occupancy(a_occ)
    );

    reg_slice_skid #(.WIDTH(8), .SKID(0), .RESET_VAL(C_RV_B)) u_dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .s_valid(b_sv), .s_ready(b_sr), .s_data(b_sd),
        .m_valid(b_mv), .m_ready(b_mr), .m_data(b_md),
        .occupancy(b_occ)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: FIFO of stored items ---------------
    logic [31:0] qa[$];
    logic [7:0]  qb[$];
    bit          ra = 1'b0;
    bit          rb = 1'b0;
    int          a_dut_outs = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            ra = 1'b0;
            rb = 1'b0;
        end else begin
            bit ia, oa, ib, ob;
            ia = a_sv && ra;
            oa = (qa.size() > 0) && a_mr;
            ib = b_sv && rb;
            ob = (qb.size() > 0) && b_mr;
            if (a_flush) qa.delete();
            else begin
                if (oa) void'(qa.pop_front());
                if (ia) qa.push_back(a_sd);
            end
            if (b_flush) qb.delete();
            else begin
                if (ob) void'(qb.pop_front());
                if (ib) qb.push_back(b_sd);
            end
            ra = (qa.size() < 2);
            rb = (qb.size() == 0);
        end
    end

    // Count transfers actually presented by DUT A.
    always @(posedge clk) begin
        if (!rst && a_mv && a_mr) a_dut_outs++;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("A s_ready", {31'd0, a_sr}, {31'd0, ra});
            check("A m_valid", {31'd0, a_mv}, {31'd0, qa.size() > 0});
            check("A occupancy", {30'd0, a_occ}, qa.size());
            if (qa.size() > 0) check("A m_data", a_md, qa[0]);
            check("B s_ready", {31'd0, b_sr}, {31'd0, rb});
            check("B m_valid", {31'd0, b_mv}, {31'd0, qb.size() > 0});
            check("B occupancy", {30'd0, b_occ}, qb.size());
            if (qb.size() > 0) check("B m_data", {24'd0, b_md}, {24'd0, qb[0]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one item into A with m_ready held low (builds up occupancy).
    task automatic a_push(input logic [31:0] d);
        a_sv = 1'b1;
        a_sd = d;
        tick();
        a_sv = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        int cycles;
        int outs0;
        logic [7:0] bdat;

        rst = 1'b1;
        a_flush = 0; a_sv = 0; a_mr = 0; a_sd = '0;
        b_flush = 0; b_sv = 0; b_mr = 0; b_sd = '0;
        repeat (3) tick();

        // Reset values
        check("rst A s_ready", {31'd0, a_sr}, 32'd0);
        check("rst A m_valid", {31'd0, a_mv}, 32'd0);
        check("rst A occupancy", {30'd0, a_occ}, 32'd0);
        check("rst A m_data", a_md, C_RV_A);
        check("rst B m_data", {24'd0, b_md}, {24'd0, C_RV_B});

        // Test 1: release, s_ready rises after the first edge, streaming
        rst = 1'b0;
        #2;
        check("release A s_ready before edge", {31'd0, a_sr}, 32'd0);
        tick();
        check("release A s_ready after edge", {31'd0, a_sr}, 32'd1);
        a_mr = 1'b1;
        a_sv = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            a_sd = k;
            tick();
            check("stream m_data", a_md, k);
            check("stream occupancy", {30'd0, a_occ}, 32'd1);
        end
        a_sv = 1'b0;
        tick();
        check("stream drained", {31'd0, a_mv}, 32'd0);

        // Test 2: backpressure into the skid entry
        a_mr = 1'b0;
        a_push(32'hA5);
        a_push(32'h5A);
        check("bp s_ready", {31'd0, a_sr}, 32'd0);
        check("bp occupancy", {30'd0, a_occ}, 32'd2);
        check("bp m_data", a_md, 32'hA5);
        tick();
        check("bp m_data held", a_md, 32'hA5);
        a_mr = 1'b1;
        tick();
        check("bp second item", a_md, 32'h5A);
        check("bp s_ready back", {31'd0, a_sr}, 32'd1);
        tick();
        check("bp empty", {31'd0, a_mv}, 32'd0);

        // Test 5: flush while FULL with a pending upstream item
        a_mr = 1'b0;
        a_push(32'h11);
        a_push(32'h22);
        a_sv = 1'b1; a_sd = 32'h33; a_flush = 1'b1;
        tick();
        a_flush = 1'b0; a_sv = 1'b0;
        check("flush m_valid", {31'd0, a_mv}, 32'd0);
        check("flush occupancy", {30'd0, a_occ}, 32'd0);
        check("flush s_ready", {31'd0, a_sr}, 32'd1);
        a_push(32'h44);
        check("post-flush m_data", a_md, 32'h44);
        a_mr = 1'b1;
        tick();

        // Test 3: random valid/ready, 1000 items, in-order delivery
        outs0 = a_dut_outs;
        sent = 0;
        cycles = 0;
        a_sd = $urandom;
        a_sv = 1'b0;
        while (sent < 1000 && cycles < 20000) begin
            bit acc;
            if (!a_sv) a_sv = ($urandom_range(0, 1) == 1);
            a_mr = ($urandom_range(0, 1) == 1);
            acc = a_sv && a_sr;
            tick();
            cycles++;
            if (acc) begin
                sent++;
                a_sd = $urandom;
                a_sv = 1'b0;
            end
        end
        a_sv = 1'b0;
        a_mr = 1'b1;
        cycles = 0;
        while (a_mv && cycles < 10) begin
            tick();
            cycles++;
        end
        check("random items sent", sent, 32'd1000);
        check("random items delivered", a_dut_outs - outs0, 32'd1000);

        // Test 4: single-entry slice alternates s_ready
        b_mr = 1'b1;
        b_sv = 1'b1;
        bdat = 8'h01;
        b_sd = bdat;
        for (int k = 0; k < 8; k++) begin
            bit acc;
            check("B s_ready alternation", {31'd0, b_sr}, (k % 2 == 0) ? 32'd1 : 32'd0);
            acc = b_sv && b_sr;
            tick();
            if (acc) begin
                check("B m_data", {24'd0, b_md}, {24'd0, bdat});
                bdat = bdat + 8'd1;
                b_sd = bdat;
            end
        end
        b_sv = 1'b0;
        tick();

        // Test 6: asynchronous reset while FULL
        a_mr = 1'b0;
        a_push(32'h77);
        a_push(32'h88);
        check("pre-reset occupancy", {30'd0, a_occ}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check("async rst m_valid", {31'd0, a_mv}, 32'd0);
        check("async rst s_ready", {31'd0, a_sr}, 32'd0);
        check("async rst occupancy", {30'd0, a_occ}, 32'd0);
        check("async rst m_data", a_md, C_RV_A);
        tick();
        #1 rst = 1'b0;
        tick();
        check("re-release s_ready", {31'd0, a_sr}, 32'd1);
        a_mr = 1'b1;
        a_sv = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_sd = 32'h100 + k;
            tick();
            check("resume m_data", a_md, 32'h100 + k);
        end
        a_sv = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
